x_uart_rx_frame: RTL

//  Parametrised UART receiver: configurable data width, parity and stop bits, with

---
 rtl/x_uart_pkg.sv | 29 ++
 rtl/x_uart_sync.sv | 25 ++
 rtl/x_uart_rx_frame.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/x_uart_pkg.sv
// Shared types and constants for the x_uart block family.
package x_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } uart_rx_state_t;

    localparam int unsigned UART_PAR_NONE = 0;
    localparam int unsigned UART_PAR_ODD  = 1;
    localparam int unsigned UART_PAR_EVEN = 2;

    // Parity error for a given mode; xor_all is XOR over data bits and parity bit.
    function automatic logic parity_err(input int unsigned mode, input logic xor_all);
        logic err;
        err = 1'b0;
        if (mode == UART_PAR_ODD) begin
            err = ~xor_all;
        end else if (mode == UART_PAR_EVEN) begin
            err = xor_all;
        end
        return err;
    endfunction

endpackage

// File: rtl/x_uart_sync.sv
// Three-flop synchroniser for an idle-high serial line: delivers the stage-2
// level and a falling-edge strobe taken between stages 2 and 3.
module x_uart_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_level,
    output logic o_fall_c
);

    logic [2:0] sync_q;

    // Shift the asynchronous line through three flops; reset to the idle level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], i_rx};
        end
    end

    assign o_level  = sync_q[1];
    assign o_fall_c = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/x_uart_rx_frame.sv
// Parametrised UART receiver: 5..9 data bits LSB first, optional odd/even
// parity, 1 or 2 checked stop bits, false-start rejection, error flags.
// Optional break detection is enabled by defining X_UART_RX_BREAK_EN.
module x_uart_rx_frame
    import x_uart_pkg::*;
#(
    parameter int unsigned p_clk_hz    = 1000000,
    parameter int unsigned p_baud      = 9600,
    parameter int unsigned p_data_bits = 8,
    parameter int unsigned p_parity    = 0,
    parameter int unsigned p_stop_bits = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx,
    output logic                   o_valid,
    output logic [p_data_bits-1:0] o_data,
    output logic                   o_parity_err,
    output logic                   o_frame_err,
    output logic                   o_break
);

    localparam int unsigned BIT_P = p_clk_hz / p_baud;
    localparam int unsigned HALF  = BIT_P / 2;
    localparam int unsigned DW    = p_data_bits;
    localparam int unsigned TMR_W = $clog2(BIT_P);
    localparam int unsigned CNT_W = $clog2(p_data_bits + 1);

    // Reject unsupported configurations at elaboration.
    if (p_data_bits < 5 || p_data_bits > 9) begin : g_bad_data_bits
        $error("x_uart_rx_frame: p_data_bits must be 5..9");
    end
    if (p_parity > 2) begin : g_bad_parity
        $error("x_uart_rx_frame: p_parity must be 0..2");
    end
    if (p_stop_bits < 1 || p_stop_bits > 2) begin : g_bad_stop_bits
        $error("x_uart_rx_frame: p_stop_bits must be 1 or 2");
    end
    if (BIT_P < 8) begin : g_bad_bit_period
        $error("x_uart_rx_frame: p_clk_hz/p_baud must be >= 8");
    end

    logic           rx_lvl;
    logic           rx_fall_c;

    uart_rx_state_t state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [DW-1:0]  shift_q, shift_d;
    logic           par_bit_q, par_bit_d;
    logic           ferr_acc_q, ferr_acc_d;
    logic           valid_q, valid_d;
    logic [DW-1:0]  data_q, data_d;
    logic           perr_q, perr_d;
    logic           ferr_q, ferr_d;

    logic           wrap_c;
    logic           mid_c;
    logic           last_data_c;
    logic           last_stop_c;

`ifdef X_UART_RX_BREAK_EN
    logic           all_low_q, all_low_d;
    logic           break_q, break_d;
    logic           brk_c;
`endif

    x_uart_sync u_sync (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_rx     (i_rx),
        .o_level  (rx_lvl),
        .o_fall_c (rx_fall_c)
    );

    assign wrap_c      = (timer_q == TMR_W'(BIT_P - 1));
    assign mid_c       = (timer_q == TMR_W'(HALF));
    assign last_data_c = (bitcnt_q == CNT_W'(DW - 1));
    assign last_stop_c = (bitcnt_q == CNT_W'(p_stop_bits - 1));
`ifdef X_UART_RX_BREAK_EN
    // Break: every sample since the start bit, including this last stop, was low.
    assign brk_c       = all_low_q & ~rx_lvl;
`endif

    // State, datapath and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef X_UART_RX_BREAK_EN
            all_low_q  <= 1'b0;
            break_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            ferr_acc_q <= ferr_acc_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
`ifdef X_UART_RX_BREAK_EN
            all_low_q  <= all_low_d;
            break_q    <= break_d;
`endif
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_fall_c) state_d = START;
            end
            START: begin
                if (mid_c) state_d = rx_lvl ? IDLE : DATA;
            end
            DATA: begin
                if (wrap_c && last_data_c) begin
                    state_d = (p_parity != UART_PAR_NONE) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (wrap_c) state_d = STOP;
            end
            STOP: begin
                if (wrap_c && last_stop_c) begin
`ifdef X_UART_RX_BREAK_EN
                    state_d = brk_c ? BRK_WAIT : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef X_UART_RX_BREAK_EN
            BRK_WAIT: begin
                if (rx_lvl) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Bit timing, sampling and next values of the registered outputs.
    always_comb begin
        timer_d    = timer_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        ferr_acc_d = ferr_acc_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
`ifdef X_UART_RX_BREAK_EN
        all_low_d  = all_low_q;
        break_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                timer_d    = '0;
                bitcnt_d   = '0;
                ferr_acc_d = 1'b0;
`ifdef X_UART_RX_BREAK_EN
                all_low_d  = 1'b1;
`endif
            end
            START: begin
                // Restart at the start-bit centre so later wraps land mid-bit.
                timer_d = mid_c ? '0 : timer_q + TMR_W'(1);
            end
            DATA: begin
                timer_d = wrap_c ? '0 : timer_q + TMR_W'(1);
                if (wrap_c) begin
                    shift_d  = {rx_lvl, shift_q[DW-1:1]};
                    bitcnt_d = last_data_c ? '0 : bitcnt_q + CNT_W'(1);
`ifdef X_UART_RX_BREAK_EN
                    all_low_d = all_low_q & ~rx_lvl;
`endif
                end
            end
            PARITY: begin
                timer_d = wrap_c ? '0 : timer_q + TMR_W'(1);
                if (wrap_c) begin
                    par_bit_d = rx_lvl;
`ifdef X_UART_RX_BREAK_EN
                    all_low_d = all_low_q & ~rx_lvl;
`endif
                end
            end
            STOP: begin
                timer_d = wrap_c ? '0 : timer_q + TMR_W'(1);
                if (wrap_c) begin
                    if (last_stop_c) begin
                        valid_d  = 1'b1;
                        data_d   = shift_q;
                        perr_d   = parity_err(p_parity, (^shift_q) ^ par_bit_q);
                        ferr_d   = ferr_acc_q | ~rx_lvl;
                        bitcnt_d = '0;
`ifdef X_UART_RX_BREAK_EN
                        break_d  = brk_c;
`endif
                    end else begin
                        ferr_acc_d = ferr_acc_q | ~rx_lvl;
                        bitcnt_d   = bitcnt_q + CNT_W'(1);
`ifdef X_UART_RX_BREAK_EN
                        all_low_d  = all_low_q & ~rx_lvl;
`endif
                    end
                end
            end
            default: begin
                timer_d  = '0;
                bitcnt_d = '0;
            end
        endcase
    end

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
`ifdef X_UART_RX_BREAK_EN
    assign o_break      = break_q;
`else
    assign o_break      = 1'b0;
`endif

endmodule
